// File: rtl/piso_pkg.sv
// piso_pkg: shared types and constants for the parallel-in, serial-out transmitter.
// Contents: FSM state enum, default word width, parity-bit count and frame length
// (both depend on the PISO_PARITY_EN macro), and the bit-counter width function.
`timescale 1ns/1ps
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

`ifdef PISO_PARITY_EN
    localparam int unsigned PARITY_BITS = 1;
`else
    localparam int unsigned PARITY_BITS = 0;
`endif

    localparam int unsigned FRAME_LEN = DEFAULT_WIDTH + PARITY_BITS;

    // Counter must hold FRAME so it can park one past the last bit without wrapping.
    function automatic int unsigned cnt_width(input int unsigned frame);
        return $clog2(frame + 1);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: clear-on-load up-counter of frame bits.
// Ports:
//   clk   - clock
//   reset - asynchronous active-low reset
//   clr   - clear to zero (a word is being loaded)
//   en    - count one frame bit
//   last  - counter sits on the final frame bit (FRAME-1)
`timescale 1ns/1ps
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int unsigned FRAME = FRAME_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int unsigned CNT_W = cnt_width(FRAME);

    logic [CNT_W-1:0] count;

    // Bit position within the current frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(FRAME - 1));

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: accepts a parallel word over a valid/ready handshake and shifts
// it out MSB first, one bit per clock, with back-to-back frames when load_valid
// is held. Define PISO_PARITY_EN to append an even-parity bit after bit 0.
// Ports:
//   clk        - clock
//   reset      - asynchronous active-low reset
//   data_in    - parallel word to transmit
//   load_valid - data_in is valid and requests transmission
//   load_ready - a word can be accepted this cycle
//   sout       - serial data bit
//   sout_valid - sout carries a frame bit this cycle
//   done       - pulse on the final bit of a frame
// All outputs are decoded from registered state only.
`timescale 1ns/1ps
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int unsigned FRAME = WIDTH + PARITY_BITS;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic             armed;
    logic             last;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             parity_q;
`endif

    piso_bit_counter #(
        .FRAME (FRAME)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (state == SHIFT),
        .last  (last)
    );

    // Next state and output decode; ready only on idle or the final frame bit.
    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                load_ready = armed;
                accept     = load_valid && armed;
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sout_valid = 1'b1;
                sout       = shreg[WIDTH-1];
                if (last) begin
`ifdef PISO_PARITY_EN
                    sout       = parity_q;
`endif
                    done       = 1'b1;
                    load_ready = 1'b1;
                    accept     = load_valid;
                    state_nxt  = load_valid ? SHIFT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; armed keeps load_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
        end
    end

    // Shift register: load on accept, otherwise zero-filled left shift while framing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= data_in;
        end else if (state == SHIFT) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

`ifdef PISO_PARITY_EN
    // Even parity of the accepted word, sent after bit 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^data_in;
        end
    end
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed bench for piso_serializer. A queue model holds the
// frame bits still to be sent; every negative edge compares all outputs to it.
// Literal checks on a serial-in receiver pin the recovered words.
`timescale 1ns/1ps
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = W + PAR;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic         sout;
    logic         sout_valid;
    logic         done;

    int errors = 0;
    int checks = 0;

    bit          exp_q[$];
    bit          armed_m = 1'b0;
    logic [31:0] rx = '0;

    piso_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of pending frame bits; head is the bit on the wire this cycle.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            armed_m = 1'b0;
        end else begin
            bit rdy;
            bit acc;
            rdy = armed_m && (exp_q.size() <= 1);
            acc = load_valid && rdy;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) begin
                for (int i = W - 1; i >= 0; i--) exp_q.push_back(data_in[i]);
`ifdef PISO_PARITY_EN
                exp_q.push_back(^data_in);
`endif
            end
            armed_m = 1'b1;
        end
    end

    // Per-cycle output comparison against the model.
    always @(negedge clk) begin
        int n;
        n = exp_q.size();
        chk("sout_valid", 32'(sout_valid), 32'(n > 0));
        chk("sout",       32'(sout),       32'((n > 0) ? exp_q[0] : 1'b0));
        chk("done",       32'(done),       32'(n == 1));
        chk("load_ready", 32'(load_ready), 32'(armed_m && (n <= 1)));
    end

    // Serial-in receiver on the same clock.
    always @(posedge clk or negedge reset) begin
        if (!reset) rx <= '0;
        else if (sout_valid) rx <= {rx[30:0], sout};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] word);
        load_valid = 1'b1;
        data_in    = word;
        tick();
        load_valid = 1'b0;
        data_in    = W'($urandom);
    endtask

    initial begin
        // Reset and idle
        repeat (3) tick();
        reset = 1'b1;
        repeat (20) tick();
        chk("idle_ready", 32'(load_ready), 32'(1));
        chk("idle_valid", 32'(sout_valid), 32'(0));

        // 0xA5 with an ignored mid-frame 0x00 request
        send(8'hA5);
        repeat (3) tick();
        load_valid = 1'b1;
        data_in    = 8'h00;
        repeat (2) tick();
        load_valid = 1'b0;
        repeat (FRAME) tick();
        chk("rx_a5", 32'(rx[PAR +: 8]), 32'h0000_00A5);

        // Back-to-back 0x3C then 0xFF
        load_valid = 1'b1;
        data_in    = 8'h3C;
        tick();
        data_in    = 8'hFF;
        repeat (FRAME) tick();
        load_valid = 1'b0;
        repeat (FRAME + 2) tick();
`ifdef PISO_PARITY_EN
        chk("rx_3cff", 32'(rx[17:0]), 32'({8'h3C, 1'b0, 8'hFF, 1'b0}));
`else
        chk("rx_3cff", 32'(rx[15:0]), 32'h0000_3CFF);
`endif

        // Reset during cycle N+4 of a 0xA5 frame
        send(8'hA5);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("rst_sout",       32'(sout),       32'(0));
        chk("rst_sout_valid", 32'(sout_valid), 32'(0));
        chk("rst_done",       32'(done),       32'(0));
        chk("rst_load_ready", 32'(load_ready), 32'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();
        send(8'h81);
        repeat (FRAME + 2) tick();
        chk("rx_81", 32'(rx[PAR +: 8]), 32'h0000_0081);

        // Parity-relevant words
        send(8'h07);
        repeat (FRAME + 2) tick();
        chk("rx_07", 32'(rx[PAR +: 8]), 32'h0000_0007);
`ifdef PISO_PARITY_EN
        chk("par_07", 32'(rx[0]), 32'(1));
`endif
        send(8'h03);
        repeat (FRAME + 2) tick();
        chk("rx_03", 32'(rx[PAR +: 8]), 32'h0000_0003);
`ifdef PISO_PARITY_EN
        chk("par_03", 32'(rx[0]), 32'(0));
`endif

        // Final idle stretch
        repeat (20) tick();
        chk("end_ready", 32'(load_ready), 32'(1));
        chk("end_done",  32'(done),       32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
